// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter and instruction-fetch request generator.
// Issues sequential (PC+4) or redirected fetch addresses over a valid/ready
// handshake and tags each request with an epoch bit for wrong-path squashing.
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   stall_i             suppress new requests (never withdraws a held one)
//   redirect_valid_i    one-cycle redirect pulse
//   redirect_target_i   redirect address (bits [1:0] must be 0, else trap)
//   fetch_ready_i       instruction memory accepts the current request
//   fetch_valid_o       request valid (combinational on stall_i)
//   fetch_addr_o        request address
//   fetch_epoch_o       epoch tag of the request
//   misalign_err_o      sticky misaligned-redirect flag
module pc_sequencer #(
  parameter int unsigned       WIDTH        = 64,
  parameter logic [WIDTH-1:0]  RESET_VECTOR = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_i,
  input  logic             redirect_valid_i,
  input  logic [WIDTH-1:0] redirect_target_i,
  input  logic             fetch_ready_i,
  output logic             fetch_valid_o,
  output logic [WIDTH-1:0] fetch_addr_o,
  output logic             fetch_epoch_o,
  output logic             misalign_err_o
);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_TRAP  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pend_target_q, pend_target_d;
  logic             pend_valid_q, pend_valid_d;
  logic             epoch_q, epoch_d;
  logic             held_q, held_d;
  logic             trap_pend_q, trap_pend_d;
  logic             misalign_q, misalign_d;

  logic             handshake;
  logic             outstanding;
  logic             target_bad;

  assign target_bad = (redirect_target_i[1:0] != 2'b00);

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_BOOT;
      pc_q          <= RESET_VECTOR;
      pend_target_q <= '0;
      pend_valid_q  <= 1'b0;
      epoch_q       <= 1'b0;
      held_q        <= 1'b0;
      trap_pend_q   <= 1'b0;
      misalign_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_target_q <= pend_target_d;
      pend_valid_q  <= pend_valid_d;
      epoch_q       <= epoch_d;
      held_q        <= held_d;
      trap_pend_q   <= trap_pend_d;
      misalign_q    <= misalign_d;
    end
  end

  // Next-state and request logic
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_target_d = pend_target_q;
    pend_valid_d  = pend_valid_q;
    epoch_d       = epoch_q;
    held_d        = 1'b0;
    trap_pend_d   = trap_pend_q;
    misalign_d    = misalign_q;
    fetch_valid_o = 1'b0;
    handshake     = 1'b0;
    outstanding   = 1'b0;

    case (state_q)
      S_BOOT: begin
        state_d = S_FETCH;
        if (redirect_valid_i) begin
          if (target_bad) begin
            misalign_d = 1'b1;
            state_d    = S_TRAP;
          end else begin
            pc_d    = redirect_target_i;
            epoch_d = ~epoch_q;
          end
        end
      end

      S_FETCH: begin
        // A held request stays up regardless of stall; a pending trap blocks new ones.
        fetch_valid_o = held_q || (!stall_i && !trap_pend_q);
        handshake     = fetch_valid_o && fetch_ready_i;
        outstanding   = fetch_valid_o && !fetch_ready_i;
        held_d        = outstanding;

        if (handshake) begin
          if (pend_valid_q) begin
            pc_d         = pend_target_q;
            pend_valid_d = 1'b0;
            epoch_d      = ~epoch_q;
          end else begin
            pc_d = pc_q + WIDTH'(4);
          end
          if (trap_pend_q) state_d = S_TRAP;
        end

        // A direct redirect overrides any pending one; epoch toggles once from epoch_q.
        if (redirect_valid_i && !trap_pend_q) begin
          if (target_bad) begin
            misalign_d = 1'b1;
            if (outstanding) trap_pend_d = 1'b1;
            else             state_d     = S_TRAP;
          end else if (outstanding) begin
            pend_target_d = redirect_target_i;
            pend_valid_d  = 1'b1;
          end else begin
            pc_d         = redirect_target_i;
            epoch_d      = ~epoch_q;
            pend_valid_d = 1'b0;
          end
        end
      end

      S_TRAP: begin
        misalign_d = 1'b1;
      end

      default: begin
        state_d = S_BOOT;
      end
    endcase
  end

  assign fetch_addr_o   = pc_q;
  assign fetch_epoch_o  = epoch_q;
  assign misalign_err_o = misalign_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed scoreboard bench for pc_sequencer: expected (addr, epoch) pairs are
// queued as stimulus is driven and compared on each observed handshake.
module tb_pc_sequencer;

  localparam int unsigned W = 64;

  logic         clk;
  logic         rst;
  logic         stall;
  logic         redirect_valid;
  logic [W-1:0] redirect_target;
  logic         fetch_ready;
  logic         fetch_valid;
  logic [W-1:0] fetch_addr;
  logic         fetch_epoch;
  logic         misalign_err;

  typedef struct packed {
    logic [W-1:0] addr;
    logic         epoch;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  pc_sequencer #(.WIDTH(W), .RESET_VECTOR('0)) dut (
    .clk               (clk),
    .rst               (rst),
    .stall_i           (stall),
    .redirect_valid_i  (redirect_valid),
    .redirect_target_i (redirect_target),
    .fetch_ready_i     (fetch_ready),
    .fetch_valid_o     (fetch_valid),
    .fetch_addr_o      (fetch_addr),
    .fetch_epoch_o     (fetch_epoch),
    .misalign_err_o    (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [W-1:0] a, input logic e);
    exp_t x;
    x.addr  = a;
    x.epoch = e;
    exp_q.push_back(x);
  endtask

  // Settle, score any handshake in this cycle, then advance to the next negedge.
  task automatic tick(input string tag);
    exp_t x;
    #1;
    if (fetch_valid && fetch_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL %s unexpected handshake observed=0x%0h expected=none", tag, fetch_addr);
      end else begin
        x = exp_q.pop_front();
        check({tag, "_addr"}, fetch_addr, x.addr);
        check({tag, "_epoch"}, W'(fetch_epoch), W'(x.epoch));
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst             = 1'b1;
    stall           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = '0;
    fetch_ready     = 1'b1;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_valid", W'(fetch_valid), '0);
    check("rst_addr", fetch_addr, '0);
    check("rst_epoch", W'(fetch_epoch), '0);
    check("rst_misalign", W'(misalign_err), '0);

    // 1: BOOT one cycle, then back-to-back 0x0, 0x4
    rst = 1'b0;
    #1 check("boot_valid", W'(fetch_valid), '0);
    tick("boot");
    push(W'(64'h0), 1'b0);
    push(W'(64'h4), 1'b0);
    tick("seq0");
    tick("seq4");

    // 2: ready low for three cycles at 0x8 with a stall pulse
    fetch_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      stall = (i == 1);
      #1;
      check("hold_valid", W'(fetch_valid), W'(1));
      check("hold_addr", fetch_addr, W'(64'h8));
      tick("hold");
    end
    stall       = 1'b0;
    fetch_ready = 1'b1;
    push(W'(64'h8), 1'b0);
    tick("hs8");
    push(W'(64'hC), 1'b0);
    tick("hsC");
    check("q_empty_t2", W'(exp_q.size()), '0);

    // 3: redirects 0x100 then 0x200 while 0x10 is held
    fetch_ready = 1'b0;
    tick("held10");
    redirect_valid  = 1'b1;
    redirect_target = W'(64'h100);
    tick("redir100");
    redirect_target = W'(64'h200);
    tick("redir200");
    redirect_valid = 1'b0;
    fetch_ready    = 1'b1;
    push(W'(64'h10), 1'b0);
    tick("hs10");
    check("pend_addr", fetch_addr, W'(64'h200));
    check("pend_epoch", W'(fetch_epoch), W'(1));
    push(W'(64'h200), 1'b1);
    tick("hs200");

    // 4: redirect 0x40 while stalled (nothing outstanding)
    stall           = 1'b1;
    redirect_valid  = 1'b1;
    redirect_target = W'(64'h40);
    #1 check("stall_valid", W'(fetch_valid), '0);
    tick("redir40");
    redirect_valid = 1'b0;
    stall          = 1'b0;
    check("r40_addr", fetch_addr, W'(64'h40));
    check("r40_epoch", W'(fetch_epoch), '0);
    push(W'(64'h40), 1'b0);
    tick("hs40");

    // Redirect coincident with a completing handshake keeps the old tag
    redirect_valid  = 1'b1;
    redirect_target = W'(64'h80);
    push(W'(64'h44), 1'b0);
    tick("hs44_redir");
    redirect_valid = 1'b0;
    push(W'(64'h80), 1'b1);
    tick("hs80");

    // 6a: wrap from 0xFFFF_FFFF_FFFF_FFFC to 0
    stall           = 1'b1;
    redirect_valid  = 1'b1;
    redirect_target = 64'hFFFF_FFFF_FFFF_FFFC;
    tick("redir_top");
    redirect_valid = 1'b0;
    stall          = 1'b0;
    push(64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    push(W'(64'h0), 1'b0);
    tick("hs_top");
    tick("hs_wrap");
    check("wrap_addr", fetch_addr, W'(64'h4));

    // 5: misaligned redirect while 0x4 is held -> completes, then TRAP
    fetch_ready = 1'b0;
    tick("held4");
    redirect_valid  = 1'b1;
    redirect_target = W'(64'h102);
    tick("redir102");
    redirect_valid = 1'b0;
    #1;
    check("mis_flag", W'(misalign_err), W'(1));
    check("mis_held_valid", W'(fetch_valid), W'(1));
    check("mis_held_addr", fetch_addr, W'(64'h4));
    fetch_ready = 1'b1;
    push(W'(64'h4), 1'b0);
    tick("hs4_trap");
    for (int i = 0; i < 3; i++) begin
      redirect_valid  = (i == 0);
      redirect_target = W'(64'h300);
      #1;
      check("trap_valid", W'(fetch_valid), '0);
      check("trap_misalign", W'(misalign_err), W'(1));
      tick("trap");
    end
    redirect_valid = 1'b0;
    check("q_empty_t5", W'(exp_q.size()), '0);

    // 6b: asynchronous reset during a held, stalled request
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1 check("boot2_misalign", W'(misalign_err), '0);
    tick("boot2");
    stall           = 1'b1;
    redirect_valid  = 1'b1;
    redirect_target = W'(64'h500);
    tick("redir500");
    redirect_valid = 1'b0;
    stall          = 1'b0;
    fetch_ready    = 1'b0;
    tick("held500");
    stall = 1'b1;
    #1;
    check("pre_rst_valid", W'(fetch_valid), W'(1));
    check("pre_rst_addr", fetch_addr, W'(64'h500));
    check("pre_rst_epoch", W'(fetch_epoch), W'(1));
    #1 rst = 1'b1;
    #1;
    check("async_valid", W'(fetch_valid), '0);
    check("async_addr", fetch_addr, '0);
    check("async_epoch", W'(fetch_epoch), '0);
    @(negedge clk);
    rst = 1'b0;

    check("q_empty_end", W'(exp_q.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
